mixcolumns_serial: RTL and testbench

Byte-serial AES MixColumns stage, directly downstream of the byte-serial ShiftRows stage. It consumes the ShiftRows output stream one byte per enabled cycle, in column-major order: bytes 0-3 are column 0, rows 0-3. It gathers each 4-byte column and applies the FIPS-197 MixColumns matrix over GF(2^8) with polynomial 0x11B. It then emits the 4 result bytes serially, one per cycle, into the AddRoundKey stage. A bypass input passes bytes through unchanged for the final round.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/mixcol_column.sv | 28 ++
 rtl/mixcolumns_serial.sv | 104 ++++++++++
 tb/tb_mixcolumns_serial.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the byte-serial datapath stages.
package aes_pkg;

    localparam logic [7:0] AES_POLY    = 8'h1B;
    localparam int         STATE_BYTES = 16;
    localparam int         COL_BYTES   = 4;
    localparam int         STATE_COLS  = STATE_BYTES / COL_BYTES;

    typedef enum logic {
        IDLE,
        EMIT
    } emit_state_t;

    // Multiply by x (i.e. by 2) in GF(2^8); poly is the low byte of the field polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly = AES_POLY);
        return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x, input logic [7:0] poly = AES_POLY);
        return xtime(x, poly) ^ x;
    endfunction

endpackage

// File: rtl/mixcol_column.sv
// Combinational MixColumns transform of one 4-byte column; row 0 sits in the top byte.
module mixcol_column
    import aes_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    always_comb begin
        r0 = xtime(a0, POLY) ^ mul3(a1, POLY) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1, POLY) ^ mul3(a2, POLY) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2, POLY) ^ mul3(a3, POLY);
        r3 = mul3(a0, POLY) ^ a1 ^ a2 ^ xtime(a3, POLY);
    end

    assign col_out = {r0, r1, r2, r3};

endmodule

// File: rtl/mixcolumns_serial.sv
// Byte-serial MixColumns: gathers column-major bytes into columns and streams the
// transformed (or bypassed) column back out one byte per cycle.
module mixcolumns_serial
    import aes_pkg::*;
#(
    parameter logic [7:0] POLY = AES_POLY
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] inbyte,
    input  logic       enable,
    input  logic       bypass,
    output logic [7:0] outbyte,
    output logic       ready,
    output logic       last
);

    logic [1:0]  row_cnt;
    logic [1:0]  col_cnt;
    logic [1:0]  emit_k;
    logic [7:0]  collect [0:COL_BYTES-2];
    logic        bypass_lat;
    logic [7:0]  emit_buf [0:COL_BYTES-1];
    logic        col3_tag;
    logic        completion;
    logic [31:0] column;
    logic [31:0] mixed;
    logic [31:0] result;

    emit_state_t state, state_next;

    // Row 3 is never stored: it feeds the transform straight from the input port.
    assign completion = enable && (row_cnt == 2'd3);
    assign column     = {collect[0], collect[1], collect[2], inbyte};
    assign result     = bypass_lat ? column : mixed;

    mixcol_column #(
        .POLY(POLY)
    ) u_column (
        .col_in (column),
        .col_out(mixed)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (completion) state_next = EMIT;
            EMIT: if (emit_k == 2'd3 && !completion) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt    <= 2'd0;
            col_cnt    <= 2'd0;
            emit_k     <= 2'd0;
            bypass_lat <= 1'b0;
            col3_tag   <= 1'b0;
            for (int i = 0; i < COL_BYTES - 1; i++) collect[i] <= 8'h00;
            for (int i = 0; i < COL_BYTES; i++) emit_buf[i] <= 8'h00;
        end else begin
            if (enable) begin
                row_cnt <= row_cnt + 2'd1;
                case (row_cnt)
                    2'd0: begin
                        collect[0] <= inbyte;
                        bypass_lat <= bypass;
                    end
                    2'd1: collect[1] <= inbyte;
                    2'd2: collect[2] <= inbyte;
                    default: ;
                endcase
            end
            // A fresh column can only arrive as the previous one finishes, so it restarts k.
            if (completion) begin
                emit_buf[0] <= result[31:24];
                emit_buf[1] <= result[23:16];
                emit_buf[2] <= result[15:8];
                emit_buf[3] <= result[7:0];
                col3_tag    <= (col_cnt == 2'(STATE_COLS - 1));
                col_cnt     <= col_cnt + 2'd1;
                emit_k      <= 2'd0;
            end else if (state == EMIT) begin
                emit_k <= emit_k + 2'd1;
            end
        end
    end

    always_comb begin
        ready   = (state == EMIT);
        outbyte = ready ? emit_buf[emit_k] : 8'h00;
        last    = ready && (emit_k == 2'd3) && col3_tag;
    end

endmodule

// File: tb/tb_mixcolumns_serial.sv
// Self-checking bench for mixcolumns_serial and its mixcol_column sub-block.
module tb_mixcolumns_serial;
    import aes_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] inbyte;
    logic       enable;
    logic       bypass;
    logic [7:0] outbyte;
    logic       ready;
    logic       last;

    logic [31:0] unit_in;
    logic [31:0] unit_out;

    int n_checks = 0;
    int n_fails  = 0;

    mixcolumns_serial #(.POLY(8'h1B)) dut (
        .clock  (clock),
        .reset  (reset),
        .inbyte (inbyte),
        .enable (enable),
        .bypass (bypass),
        .outbyte(outbyte),
        .ready  (ready),
        .last   (last)
    );

    mixcol_column #(.POLY(8'h1B)) u_unit (
        .col_in (unit_in),
        .col_out(unit_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] b;
        logic       last;
    } exp_t;

    typedef struct {
        logic [31:0] col_in;
        logic        byp;
        logic [31:0] expected;
    } vec_t;

    // Reference model state: queue of expected output bytes and the collecting column.
    exp_t       exp_q[$];
    logic [7:0] m_col [4];
    int         m_row;
    int         m_colidx;
    logic       m_byp;
    logic       expect_zero;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p ^= (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [31:0] ref_mix(input logic [31:0] c);
        logic [7:0] m [4][4];
        logic [7:0] a [4];
        logic [7:0] r;
        logic [31:0] res;
        m = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
              '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
        for (int j = 0; j < 4; j++) a[j] = c[31 - 8*j -: 8];
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
            r = 8'h00;
            for (int j = 0; j < 4; j++) r ^= gf_mul(m[i][j], a[j]);
            res[31 - 8*i -: 8] = r;
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        check("ready", 32'(ready), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outbyte", 32'(outbyte), 32'(e.b));
            check("last", 32'(last), 32'(e.last));
        end else begin
            check("last_idle", 32'(last), 32'h0);
            if (expect_zero) check("outbyte_after_reset", 32'(outbyte), 32'h0);
        end
        expect_zero = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic [7:0] b, input logic byp, input logic rst);
        logic [31:0] c, r;
        exp_t e;
        if (rst) begin
            exp_q.delete();
            m_row = 0;
            m_colidx = 0;
            m_byp = 1'b0;
            expect_zero = 1'b1;
        end else if (en) begin
            if (m_row == 0) m_byp = byp;
            m_col[m_row] = b;
            m_row++;
            if (m_row == 4) begin
                c = {m_col[0], m_col[1], m_col[2], m_col[3]};
                r = m_byp ? c : ref_mix(c);
                for (int i = 0; i < 4; i++) begin
                    e.b = r[31 - 8*i -: 8];
                    e.last = (m_colidx == 3) && (i == 3);
                    exp_q.push_back(e);
                end
                m_colidx = (m_colidx + 1) % 4;
                m_row = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] b, input logic byp, input logic rst);
        @(negedge clock);
        checkOutput();
        enable = en;
        inbyte = b;
        bypass = byp;
        reset  = rst;
        @(posedge clock);
        model_edge(en, b, byp, rst);
    endtask

    task automatic feed_column(input logic [31:0] c, input logic byp, input int gap);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, c[31 - 8*i -: 8], byp, 1'b0);
            if (i < 3) for (int g = 0; g < gap; g++) applyStimulus(1'b0, 8'h00, byp, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{32'hdb135345, 1'b0, 32'h8e4da1bc};
        vecs[1] = '{32'hf20a225c, 1'b0, 32'h9fdc589d};
        vecs[2] = '{32'h01010101, 1'b0, 32'h01010101};
        vecs[3] = '{32'hd4d4d4d5, 1'b0, 32'hd5d5d7d6};
        vecs[4] = '{32'h2d26314c, 1'b0, 32'h4d7ebdf8};
        vecs[5] = '{32'hc6c6c6c6, 1'b1, 32'hc6c6c6c6};
        vecs[6] = '{32'hd4d4d4d5, 1'b1, 32'hd4d4d4d5};

        reset = 1'b1; enable = 1'b0; inbyte = 8'h00; bypass = 1'b0;
        unit_in = 32'h0;
        m_row = 0; m_colidx = 0; m_byp = 1'b0; expect_zero = 1'b0;
        repeat (2) @(posedge clock);
        model_edge(1'b0, 8'h00, 1'b0, 1'b1);

        // Reset takes priority over a coincident enable
        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);

        // Combinational column block against the known FIPS vectors
        for (int i = 0; i < 7; i++) begin
            unit_in = vecs[i].col_in;
            #1;
            if (!vecs[i].byp) check("unit_vector", unit_out, vecs[i].expected);
        end

        // Single FIPS column, then a full back-to-back state (last only on the final byte)
        feed_column(vecs[0].col_in, 1'b0, 0);
        idle(5);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) feed_column(vecs[i].col_in, vecs[i].byp, 0);
        idle(5);

        // Gapped enable
        feed_column(vecs[4].col_in, 1'b0, 3);
        idle(5);

        // Bypass columns, with bypass dropped on row 2 of the second one
        feed_column(vecs[5].col_in, 1'b1, 0);
        applyStimulus(1'b1, 8'hd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hd4, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hd4, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hd5, 1'b0, 1'b0);
        idle(5);

        // Reset after two bytes, then reset during emission, then a clean column
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        feed_column(vecs[1].col_in, 1'b0, 0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        feed_column(32'h01010101, 1'b0, 0);
        idle(5);

        // Randomised stream with random gaps and bypass
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 7) == 0), 1'b0);
        idle(6);

        // Random columns and every xtime input against the bench field arithmetic
        for (int i = 0; i < 300; i++) begin
            unit_in = $urandom;
            #1;
            check("unit_random", unit_out, ref_mix(unit_in));
        end
        for (int x = 0; x < 256; x++) check("xtime", 32'(xtime(8'(x))), 32'(gf_mul(8'(x), 8'h02)));
        check("xtime_80", 32'(xtime(8'h80)), 32'h1b);
        check("xtime_57", 32'(xtime(8'h57)), 32'hae);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
